uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

UART byte receiver, the downstream partner of `uart_byte_tx`: it deserialises the 8N1 stream on `rx` back into a parallel byte. The block uses a 50 MHz system clock and the same `set_baud` encoding as the transmitter, so the two connect directly for loopback and board-to-board links. It uses 16x oversampling with 3-sample majority voting, rejects glitch start bits and flags bad stop bits.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz; used only to derive the divider table.
- `clk` input 1: system clock, 50 MHz (20 ns period).
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `set_baud` input 3: baud select.
  - 0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200.
  - 5–7 = 9600.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `data_byte` output 8: last received byte; holds its value until the next frame completes.
- `rx_done` output 1: one-clk pulse when a frame completes.
- `uart_state` output 1: 1 while a frame is being received.
- `frame_err` output 1: stop-bit status of the last frame; valid from `rx_done` until the next `rx_done`.

## Operation
- **Synchroniser:** `rx` passes through 2 flops (`rx_s1`, `rx_s2`), plus an edge flop `rx_s3`.
  - All three reset to 1.
  - Start edge = `rx_s3 & ~rx_s2`.
- **Divider table, DIV = CLK_FREQ / (baud·16):** 9600→325, 19200→162, 38400→81, 57600→54, 115200→27.
  - The divider value is selected from `set_baud` and latched on start-edge detection.
  - `set_baud` changes mid-frame have no effect.
- **Divider counter:** counts 0..DIV-1 while `uart_state` = 1.
  - `tick` = 1 for one clk when the count equals DIV-1.
  - The counter is cleared when idle.
- **Tick counter:** 8-bit `tick_cnt`, 0..154, advances on each `tick`.
  - Bit index i = 0 (start), 1–8 (data, LSB first), 9 (stop).
- **Sampling:** each bit is sampled at tick counts i·16+7, +8, +9 (3 samples of `rx_s2`).
  - The 2-of-3 majority becomes the bit value, decided at tick count i·16+10.
- **States:**
  - IDLE: start edge → START. `uart_state` ← 1, counters cleared.
  - START: at tick count 10, majority = 1 (glitch) → IDLE, with no `rx_done` and no output change. Majority = 0 → DATA.
  - DATA: at tick counts 26, 42, …, 138, the decided bit is shifted into bit 0..7 of the shift register. After bit 8 → STOP.
  - STOP: at tick count 154, `data_byte` ← shift register, `frame_err` ← ~stop_majority, `rx_done` ← 1 for one clk, `uart_state` ← 0 on the same edge; state → IDLE.
- Returning to IDLE at mid-stop-bit lets a back-to-back start edge, arriving one half-bit later, be caught.
- A frame with a framing error still updates `data_byte` and pulses `rx_done`.
- **Reset (any time, including mid-frame):**
  - State → IDLE.
  - Outputs: `data_byte` = 8'h00, `rx_done` = 0, `uart_state` = 0, `frame_err` = 0.
  - Counters are cleared and the synchroniser is set to 1.
  - The remainder of an interrupted frame may be seen as new start edges; each is then subject to start validation.

## Timing
- Start-edge detection occurs 3 clk after the `rx` fall: 2 synchroniser stages plus the edge flop.
- `rx_done` occurs 155·DIV clk after detection (the 154th divider tick plus the decision register), within ±1 clk.
  - 115200 baud: ≈ 4185 clk ≈ 83.7 µs after the start-bit fall.
  - 9600 baud: ≈ 50 375 clk.
- `rx_done` is high for exactly 1 clk. `data_byte` and `frame_err` are valid in the same cycle and remain stable afterwards.
- Maximum tolerated combined baud error: ±3 %. Sample placement is at 7–9/16 of each bit.
- Glitch rejection: an `rx` low pulse shorter than 7/16 bit never yields `rx_done`. `uart_state` returns to 0 at tick count 10 (≈ 11·DIV clk after detection).

## Test plan
- **Loopback, 9600:** `uart_byte_tx` → `rx`, `set_baud` = 0, byte 8'h0F. Expect `data_byte` = 8'h0F, a 1-clk `rx_done`, `frame_err` = 0, and `uart_state` low after `rx_done`.
- **Back-to-back at 115200:** `set_baud` = 4, bytes 8'hAA then 8'hEE with no idle gap. Expect two `rx_done` pulses about 4340 clk apart carrying 8'hAA and 8'hEE, with `frame_err` = 0 both times.
- **Glitch:** `set_baud` = 0, `rx` held low for 5 clk while idle. Expect no `rx_done`, `uart_state` back to 0 within 11·325+5 clk, and `data_byte` unchanged.
- **Framing error:** at 38400, drive 8'h55 with stop bit = 0. Expect `rx_done` pulse, `data_byte` = 8'h55, `frame_err` = 1. The next good frame with 8'h3C gives `frame_err` = 0.
- **Reset mid-frame:** assert `rst_n` = 0 at data bit 4 of a 57600 frame.
  - During reset: all outputs 0 asynchronously.
  - After release: line held idle for 2 bit times, then 8'hC3 is sent. Expect exactly one `rx_done`, with `data_byte` = 8'hC3.
- **Out-of-range select:** `set_baud` = 7, byte 8'h81 sent at 9600. Expect `data_byte` = 8'h81 and `frame_err` = 0.

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver, 16x oversampling,
// 3-sample majority vote, glitch-start reject, stop check.
`timescale 1ns/1ps
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] set_baud,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       uart_state,
  output logic       frame_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] DIV0 =
    16'(CLK_FREQ / (9600 * 16));
  localparam logic [15:0] DIV1 =
    16'(CLK_FREQ / (19200 * 16));
  localparam logic [15:0] DIV2 =
    16'(CLK_FREQ / (38400 * 16));
  localparam logic [15:0] DIV3 =
    16'(CLK_FREQ / (57600 * 16));
  localparam logic [15:0] DIV4 =
    16'(CLK_FREQ / (115200 * 16));

  logic        rx_s1, rx_s2, rx_s3;
  logic        start_edge;
  logic [15:0] div_sel;
  logic [15:0] div_q;
  logic [15:0] div_cnt;
  logic        tick;
  logic [7:0]  tick_cnt;
  logic        samp_en;
  logic        decide;
  logic [2:0]  samp;
  logic        maj;
  logic [7:0]  shreg;
  logic [1:0]  state;

  // two-flop synchroniser plus edge-detect flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign start_edge = rx_s3 & ~rx_s2;

  // baud select to divider; unlisted codes fall back to 9600
  always_comb begin
    div_sel = DIV0;
    unique case (1'b1)
      set_baud == 3'd1: div_sel = DIV1;
      set_baud == 3'd2: div_sel = DIV2;
      set_baud == 3'd3: div_sel = DIV3;
      set_baud == 3'd4: div_sel = DIV4;
      default:          div_sel = DIV0;
    endcase
  end

  assign tick = uart_state &&
                (div_cnt == div_q - 16'd1);

  // oversampling divider, held at zero while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (!uart_state || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 16'd1;
  end

  // 1/16-bit position within the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt <= '0;
    else if (!uart_state)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= tick_cnt + 8'd1;
  end

  assign samp_en = tick &&
                   (tick_cnt[3:0] >= 4'd7) &&
                   (tick_cnt[3:0] <= 4'd9);
  assign decide  = tick &&
                   (tick_cnt[3:0] == 4'd10);
  assign maj = (samp[0] & samp[1]) |
               (samp[0] & samp[2]) |
               (samp[1] & samp[2]);

  // three mid-bit samples feeding the majority vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      samp <= 3'b111;
    else if (samp_en)
      samp <= {samp[1:0], rx_s2};
  end

  // frame FSM: start check, LSB-first shift, stop check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_q      <= DIV0;
      shreg      <= '0;
      data_byte  <= '0;
      rx_done    <= 1'b0;
      uart_state <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state      <= START;
            uart_state <= 1'b1;
            div_q      <= div_sel;
          end
        end
        START: begin
          if (decide) begin
            if (maj) begin
              state      <= IDLE;
              uart_state <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shreg <= {maj, shreg[7:1]};
            if (tick_cnt == 8'd138)
              state <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            data_byte  <= shreg;
            frame_err  <= ~maj;
            rx_done    <= 1'b1;
            uart_state <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: table vectors, corner sequences and
// random frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  // reduced clock keeps 9600-baud frames short
  localparam int CF = 10_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic [2:0] set_baud = 3'd0;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       uart_state;
  logic       frame_err;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] b;
    logic       stop;
    logic [7:0] eb;
    logic       efe;
    int         elat;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       fe;
    logic       st;
    int         c;
  } done_t;

  vec_t  vt[7];
  done_t dq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    wide = 0;
  int    fall_cyc = 0;
  logic  prev_done = 1'b0;

  uart_byte_rx #(.CLK_FREQ(CF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_baud  (set_baud),
    .rx        (rx),
    .data_byte (data_byte),
    .rx_done   (rx_done),
    .uart_state(uart_state),
    .frame_err (frame_err)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done && rst_n)
      dq.push_back('{b: data_byte, fe: frame_err,
                     st: uart_state, c: cyc});
    if (rx_done && prev_done) wide <= wide + 1;
    prev_done <= rx_done;
  end

  function automatic int div_of(input logic [2:0] s);
    int baud;
    case (s)
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    return CF / (baud * 16);
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input int act,
                          input int exp, input int tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d+-%0d",
               nm, act, exp, tol);
    end
  endtask

  // call at posedge+1; returns at posedge+1 after stop bit
  task automatic send_frame(input logic [2:0] s,
                            input logic [7:0] b,
                            input logic stop,
                            input bit scramble);
    logic [9:0] f;
    int bt;
    f = {stop, b, 1'b0};
    bt = 16 * div_of(s);
    set_baud = s;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      if (i == 0) fall_cyc = cyc;
      if (scramble && i == 3) set_baud = 3'($urandom);
      repeat (bt) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  initial begin
    done_t      d;
    logic [2:0] s;
    logic [7:0] b;
    logic       st;
    logic [9:0] f;
    int         gap;
    int         dv;

    vt[0] = '{sel: 3'd0, b: 8'h0F, stop: 1'b1,
              eb: 8'h0F, efe: 1'b0, elat: 10078};
    vt[1] = '{sel: 3'd2, b: 8'h55, stop: 1'b0,
              eb: 8'h55, efe: 1'b1, elat: 2483};
    vt[2] = '{sel: 3'd2, b: 8'h3C, stop: 1'b1,
              eb: 8'h3C, efe: 1'b0, elat: 2483};
    vt[3] = '{sel: 3'd7, b: 8'h81, stop: 1'b1,
              eb: 8'h81, efe: 1'b0, elat: 10078};
    vt[4] = '{sel: 3'd1, b: 8'h96, stop: 1'b1,
              eb: 8'h96, efe: 1'b0, elat: 4963};
    vt[5] = '{sel: 3'd3, b: 8'h00, stop: 1'b0,
              eb: 8'h00, efe: 1'b1, elat: 1553};
    vt[6] = '{sel: 3'd4, b: 8'hFF, stop: 1'b1,
              eb: 8'hFF, efe: 1'b0, elat: 778};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data", data_byte, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_state", uart_state, 0);
    chk("rst_ferr", frame_err, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      send_frame(vt[i].sel, vt[i].b, vt[i].stop, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("tbl_cnt", dq.size(), 1);
      if (dq.size() > 0) begin
        d = dq.pop_front();
        chk("tbl_byte", d.b, vt[i].eb);
        chk("tbl_ferr", d.fe, vt[i].efe);
        chk("tbl_state", d.st, 0);
        chk_near("tbl_lat", d.c - fall_cyc, vt[i].elat, 2);
      end
      chk("tbl_hold", data_byte, vt[i].eb);
      chk("tbl_idle", uart_state, 0);
      dq.delete();
      repeat (6) @(posedge clk);
      #1;
    end

    send_frame(3'd4, 8'hAA, 1'b1, 1'b0);
    send_frame(3'd4, 8'hEE, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_cnt", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("b2b_byte0", dq[0].b, 8'hAA);
      chk("b2b_byte1", dq[1].b, 8'hEE);
      chk("b2b_ferr0", dq[0].fe, 0);
      chk("b2b_ferr1", dq[1].fe, 0);
      chk_near("b2b_gap", dq[1].c - dq[0].c,
               160 * div_of(3'd4), 2);
    end
    dq.delete();
    repeat (10) @(posedge clk);
    #1;

    set_baud = 3'd0;
    dv = div_of(3'd0);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    chk("glitch_busy", uart_state, 1);
    repeat (11 * dv - 6) @(posedge clk);
    #1;
    chk("glitch_still", uart_state, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("glitch_idle", uart_state, 0);
    chk("glitch_done", dq.size(), 0);
    chk("glitch_data", data_byte, 8'hEE);
    repeat (10) @(posedge clk);
    #1;

    f = {1'b1, 8'hA5, 1'b0};
    set_baud = 3'd3;
    dv = div_of(3'd3);
    for (int i = 0; i < 5; i++) begin
      rx = f[i];
      repeat (16 * dv) @(posedge clk);
      #1;
    end
    rx = f[5];
    repeat (8 * dv) @(posedge clk);
    #20;
    chk("mid_busy", uart_state, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", data_byte, 0);
    chk("mid_rst_done", rx_done, 0);
    chk("mid_rst_state", uart_state, 0);
    chk("mid_rst_ferr", frame_err, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (32 * dv) @(posedge clk);
    #1;
    dq.delete();
    send_frame(3'd3, 8'hC3, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_cnt", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("mid_byte", dq[0].b, 8'hC3);
      chk("mid_ferr", dq[0].fe, 0);
    end
    dq.delete();
    repeat (10) @(posedge clk);
    #1;

    for (int k = 0; k < 10; k++) begin
      s  = 3'($urandom_range(4, 1));
      b  = 8'($urandom);
      st = ($urandom_range(3, 0) != 0);
      send_frame(s, b, st, 1'b1);
      chk("rnd_cnt", dq.size(), 1);
      if (dq.size() > 0) begin
        d = dq.pop_front();
        chk("rnd_byte", d.b, b);
        chk("rnd_ferr", d.fe, !st);
        chk_near("rnd_lat", d.c - fall_cyc,
                 3 + 155 * div_of(s), 2);
      end
      dq.delete();
      gap = st ? $urandom_range(2, 0)
               : $urandom_range(6, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    repeat (10) @(posedge clk);
    #1;
    chk("done_width", wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
